// File: rtl/risc_control_ws.sv
// ---------------------------------------------------------------------------
// risc_control_ws
//
// Instruction sequencer for the 8-opcode accumulator RISC CPU. It steps an
// 8-phase fetch/execute cycle and decodes the datapath strobes from the
// registered phase, the IR opcode and the accumulator-zero flag. Compared with
// the basic control unit it adds the following:
//   - memory wait states, with a stall timeout that raises bus_err
//   - a latched HALTED state that the go input releases
//   - single-step mode, using the PAUSE state after each retire
//   - illegal-opcode detection for opcode fields wider than 3 bits
//   - a counter of retired instructions
//
// Ports
//   clk        in   system clock, rising edge
//   rst_       in   asynchronous active-low reset
//   zero       in   accumulator-zero flag (used by SKZ)
//   opcode     in   IR opcode field [OP_W-1:0]
//   mem_rdy    in   memory ready, looked at only in stall phases
//   go         in   releases HALTED / PAUSE
//   step_en    in   single-step mode enable
//   rd/wr      out  memory read / write
//   ld_ir      out  load instruction register
//   ld_ac      out  load accumulator
//   ld_pc      out  load program counter
//   inc_pc     out  increment program counter
//   halt       out  CPU halted
//   data_e     out  accumulator drives the data bus
//   sel        out  address mux: PC (1) or IR operand (0)
//   phase      out  current phase, 0 outside RUN
//   paused     out  in PAUSE state
//   ill_op     out  sticky illegal-opcode flag
//   bus_err    out  sticky memory-timeout flag
//   instr_cnt  out  retired instruction count
// ---------------------------------------------------------------------------
module risc_control_ws #(
  parameter int OP_W        = 3,
  parameter int RDY_TIMEOUT = 16,
  parameter int TO_W        = 5,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             zero,
  input  logic [OP_W-1:0]  opcode,
  input  logic             mem_rdy,
  input  logic             go,
  input  logic             step_en,
  output logic             rd,
  output logic             wr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             halt,
  output logic             data_e,
  output logic             sel,
  output logic [2:0]       phase,
  output logic             paused,
  output logic             ill_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_PAUSE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam bit            TO_EN  = (RDY_TIMEOUT > 0);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(RDY_TIMEOUT);
  localparam logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}};

  state_t           r_state;
  logic [2:0]       r_phase;
  logic [TO_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0] r_instr_cnt;
  logic             r_ill_op;
  logic             r_bus_err;

  logic             w_upper_nz;
  logic             w_illegal;
  logic [2:0]       w_op;
  logic             w_aluop;
  logic             w_stall_phase;

  // Opcode decode. An illegal opcode is mapped onto HLT so that it can never
  // raise a datapath strobe.
  always_comb begin
    w_upper_nz = 1'b0;
    for (int i = 3; i < OP_W; i++) begin
      w_upper_nz = w_upper_nz | opcode[i];
    end
    w_illegal     = w_upper_nz;
    w_op          = w_illegal ? OP_HLT : opcode[2:0];
    w_aluop       = (w_op == OP_ADD) || (w_op == OP_AND) ||
                    (w_op == OP_XOR) || (w_op == OP_LDA);
    w_stall_phase = (r_phase == 3'd1) ||
                    ((r_phase == 3'd5) && w_aluop) ||
                    ((r_phase == 3'd7) && (w_op == OP_STO));
  end

  // Sequencer: top-level state, phase, stall counter, sticky flags and the
  // retire counter.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= ST_RUN;
      r_phase     <= 3'd0;
      r_stall_cnt <= '0;
      r_instr_cnt <= '0;
      r_ill_op    <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_stall_phase && !mem_rdy) begin
            // Waiting on memory. The strobes stay as decoded while we wait.
            if (TO_EN && (r_stall_cnt == TO_LIM)) begin
              r_state     <= ST_HALTED;
              r_phase     <= 3'd0;
              r_stall_cnt <= '0;
              r_bus_err   <= 1'b1;
            end else if (r_stall_cnt != TO_MAX) begin
              r_stall_cnt <= r_stall_cnt + 1'b1;
            end
          end else begin
            r_stall_cnt <= '0;
            case (r_phase)
              3'd4: begin
                if (w_illegal) begin
                  r_state  <= ST_HALTED;
                  r_phase  <= 3'd0;
                  r_ill_op <= 1'b1;
                end else if (w_op == OP_HLT) begin
                  r_state <= ST_HALTED;
                  r_phase <= 3'd0;
                end else begin
                  r_phase <= 3'd5;
                end
              end
              3'd7: begin
                // Retire. The step_en value seen here picks the next state.
                r_instr_cnt <= r_instr_cnt + 1'b1;
                r_phase     <= 3'd0;
                r_state     <= step_en ? ST_PAUSE : ST_RUN;
              end
              default: r_phase <= r_phase + 3'd1;
            endcase
          end
        end
        ST_HALTED: begin
          if (go) begin
            r_state     <= ST_RUN;
            r_phase     <= 3'd0;
            r_stall_cnt <= '0;
            r_ill_op    <= 1'b0;
            r_bus_err   <= 1'b0;
          end
        end
        ST_PAUSE: begin
          if (go) begin
            r_state     <= ST_RUN;
            r_phase     <= 3'd0;
            r_stall_cnt <= '0;
          end
        end
        default: begin
          // An unreachable encoding parks the sequencer in HALTED.
          r_state     <= ST_HALTED;
          r_phase     <= 3'd0;
          r_stall_cnt <= '0;
        end
      endcase
    end
  end

  // Strobe decode from the registered state, phase, opcode and zero flag.
  always_comb begin
    rd     = 1'b0;
    wr     = 1'b0;
    ld_ir  = 1'b0;
    ld_ac  = 1'b0;
    ld_pc  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    data_e = 1'b0;
    sel    = 1'b0;
    case (r_state)
      ST_RUN: begin
        case (r_phase)
          3'd0: sel = 1'b1;
          3'd1: begin
            sel = 1'b1;
            rd  = 1'b1;
          end
          3'd2: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
          end
          3'd3: begin
            sel = 1'b1;
            rd  = 1'b1;
          end
          3'd4: begin
            inc_pc = 1'b1;
            halt   = (w_op == OP_HLT);
          end
          3'd5: rd = w_aluop;
          3'd6: begin
            rd     = w_aluop;
            inc_pc = (w_op == OP_SKZ) && zero;
            ld_pc  = (w_op == OP_JMP);
            data_e = (w_op == OP_STO);
          end
          3'd7: begin
            rd     = w_aluop;
            ld_ac  = w_aluop;
            ld_pc  = (w_op == OP_JMP);
            wr     = (w_op == OP_STO);
            data_e = (w_op == OP_STO);
          end
          default: sel = 1'b0;
        endcase
      end
      ST_HALTED: halt = 1'b1;
      ST_PAUSE:  halt = 1'b0;
      default:   halt = 1'b1;
    endcase
  end

  assign phase     = r_phase;
  assign paused    = (r_state == ST_PAUSE);
  assign ill_op    = r_ill_op;
  assign bus_err   = r_bus_err;
  assign instr_cnt = r_instr_cnt;

endmodule

// File: tb/tb_risc_control_ws.sv
module tb_risc_control_ws;

  localparam int OP_W  = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_;
  logic             zero;
  logic [OP_W-1:0]  opcode;
  logic             mem_rdy;
  logic             go;
  logic             step_en;
  logic             rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel;
  logic [2:0]       phase;
  logic             paused, ill_op, bus_err;
  logic [CNT_W-1:0] instr_cnt;

  risc_control_ws #(
    .OP_W(OP_W), .RDY_TIMEOUT(4), .TO_W(5), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_(rst_), .zero(zero), .opcode(opcode), .mem_rdy(mem_rdy),
    .go(go), .step_en(step_en), .rd(rd), .wr(wr), .ld_ir(ld_ir), .ld_ac(ld_ac),
    .ld_pc(ld_pc), .inc_pc(inc_pc), .halt(halt), .data_e(data_e), .sel(sel),
    .phase(phase), .paused(paused), .ill_op(ill_op), .bus_err(bus_err),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // Strobe vector order: {rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel}
  localparam logic [8:0] S_P0   = 9'h001;
  localparam logic [8:0] S_P1   = 9'h101;
  localparam logic [8:0] S_P2   = 9'h141;
  localparam logic [8:0] S_P3   = 9'h101;
  localparam logic [8:0] S_P4   = 9'h008;
  localparam logic [8:0] S_HLT4 = 9'h00C;
  localparam logic [8:0] S_HALT = 9'h004;
  localparam logic [8:0] S_NONE = 9'h000;
  localparam logic [8:0] S_RD   = 9'h100;
  localparam logic [8:0] S_RDAC = 9'h120;
  localparam logic [8:0] S_DE   = 9'h002;
  localparam logic [8:0] S_WRDE = 9'h082;
  localparam logic [8:0] S_INC  = 9'h008;
  localparam logic [8:0] S_LDPC = 9'h010;
  // Flag order: {paused, ill_op, bus_err}
  localparam logic [2:0] F_NONE  = 3'b000;
  localparam logic [2:0] F_PAUSE = 3'b100;
  localparam logic [2:0] F_ILL   = 3'b010;
  localparam logic [2:0] F_BUS   = 3'b001;

  localparam logic [3:0] OP_HLT = 4'b0000;
  localparam logic [3:0] OP_SKZ = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_LDA = 4'b0101;
  localparam logic [3:0] OP_STO = 4'b0110;
  localparam logic [3:0] OP_JMP = 4'b0111;
  localparam logic [3:0] OP_BAD = 4'b1010;

  typedef struct {
    int          cyc;
    logic [14:0] exp;
    logic [15:0] exp_cnt;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_num  = 0;

  wire [14:0] w_obs = {rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, halt, data_e, sel,
                       paused, ill_op, bus_err, phase};

  always @(posedge clk) cyc_num <= cyc_num + 1;

  // Monitor: pops the expectation belonging to the current cycle at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc < cyc_num) begin
      e = sb_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: cycle %0d not sampled, required outs=%b cnt=%0d",
               e.name, e.cyc, e.exp, e.exp_cnt);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc_num) begin
      e = sb_q.pop_front();
      n_checks++;
      if ((w_obs !== e.exp) || (instr_cnt !== e.exp_cnt)) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 e.name, cyc_num, w_obs, instr_cnt, e.exp, e.exp_cnt);
      end
    end
  end

  task automatic tick(input logic [8:0] s, input logic [2:0] ph, input logic [2:0] fl,
                      input logic [15:0] c, input string nm);
    exp_t e;
    e.cyc     = cyc_num;
    e.exp     = {s, fl, ph};
    e.exp_cnt = c;
    e.name    = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [15:0] c, input string nm);
    tick(S_P0, 3'd0, F_NONE, c, {nm, "_p0"});
    tick(S_P1, 3'd1, F_NONE, c, {nm, "_p1"});
    tick(S_P2, 3'd2, F_NONE, c, {nm, "_p2"});
    tick(S_P3, 3'd3, F_NONE, c, {nm, "_p3"});
  endtask

  task automatic run_instr(input logic [3:0] op, input logic z, input logic [8:0] s5,
                           input logic [8:0] s6, input logic [8:0] s7,
                           input logic [15:0] c, input string nm);
    opcode  = op;
    zero    = z;
    mem_rdy = 1'b1;
    fetch(c, nm);
    tick(S_P4, 3'd4, F_NONE, c, {nm, "_p4"});
    tick(s5,   3'd5, F_NONE, c, {nm, "_p5"});
    tick(s6,   3'd6, F_NONE, c, {nm, "_p6"});
    tick(s7,   3'd7, F_NONE, c, {nm, "_p7"});
  endtask

  initial begin
    rst_    = 1'b0;
    zero    = 1'b0;
    mem_rdy = 1'b1;
    go      = 1'b0;
    step_en = 1'b0;
    opcode  = OP_LDA;
    repeat (2) @(posedge clk);
    #1;
    tick(S_P0, 3'd0, F_NONE, 16'd0, "reset_state");
    rst_ = 1'b1;

    // Free-running LDA: 8 cycles per instruction
    run_instr(OP_LDA, 1'b0, S_RD, S_RD, S_RDAC, 16'd0, "lda1");
    run_instr(OP_LDA, 1'b0, S_RD, S_RD, S_RDAC, 16'd1, "lda2");

    // STO with 3 wait states in phase 1 and 2 in phase 7 (13 cycles)
    opcode = OP_STO;
    tick(S_P0, 3'd0, F_NONE, 16'd2, "sto_p0");
    mem_rdy = 1'b0;
    repeat (3) tick(S_P1, 3'd1, F_NONE, 16'd2, "sto_p1_stall");
    mem_rdy = 1'b1;
    tick(S_P1, 3'd1, F_NONE, 16'd2, "sto_p1_rdy");
    tick(S_P2, 3'd2, F_NONE, 16'd2, "sto_p2");
    tick(S_P3, 3'd3, F_NONE, 16'd2, "sto_p3");
    tick(S_P4, 3'd4, F_NONE, 16'd2, "sto_p4");
    mem_rdy = 1'b0;
    tick(S_NONE, 3'd5, F_NONE, 16'd2, "sto_p5_rdy_ignored");
    tick(S_DE,   3'd6, F_NONE, 16'd2, "sto_p6_rdy_ignored");
    repeat (2) tick(S_WRDE, 3'd7, F_NONE, 16'd2, "sto_p7_stall");
    mem_rdy = 1'b1;
    tick(S_WRDE, 3'd7, F_NONE, 16'd2, "sto_p7_rdy");

    // Branches
    run_instr(OP_SKZ, 1'b1, S_NONE, S_INC,  S_NONE, 16'd3, "skz_z1");
    run_instr(OP_SKZ, 1'b0, S_NONE, S_NONE, S_NONE, 16'd4, "skz_z0");
    run_instr(OP_JMP, 1'b0, S_NONE, S_LDPC, S_LDPC, 16'd5, "jmp");

    // HLT, 10 idle cycles, then go
    opcode = OP_HLT;
    fetch(16'd6, "hlt");
    tick(S_HLT4, 3'd4, F_NONE, 16'd6, "hlt_p4");
    repeat (10) tick(S_HALT, 3'd0, F_NONE, 16'd6, "hlt_idle");
    go = 1'b1;
    tick(S_HALT, 3'd0, F_NONE, 16'd6, "hlt_go");
    go = 1'b0;

    // ADD with memory stuck in phase 5: timeout after 4 stalled cycles
    opcode = OP_ADD;
    fetch(16'd6, "add");
    tick(S_P4, 3'd4, F_NONE, 16'd6, "add_p4");
    mem_rdy = 1'b0;
    repeat (5) tick(S_RD, 3'd5, F_NONE, 16'd6, "add_p5_stall");
    repeat (2) tick(S_HALT, 3'd0, F_BUS, 16'd6, "bus_err_halt");
    step_en = 1'b1;
    go      = 1'b1;
    tick(S_HALT, 3'd0, F_BUS, 16'd6, "bus_err_go");
    go = 1'b0;

    // Single step: PAUSE after retire until go
    run_instr(OP_LDA, 1'b0, S_RD, S_RD, S_RDAC, 16'd6, "step_lda");
    repeat (3) tick(S_NONE, 3'd0, F_PAUSE, 16'd7, "paused");
    step_en = 1'b0;
    go      = 1'b1;
    tick(S_NONE, 3'd0, F_PAUSE, 16'd7, "pause_go");
    go = 1'b0;

    // Illegal opcode with the upper bit set
    opcode = OP_BAD;
    fetch(16'd7, "ill");
    tick(S_HLT4, 3'd4, F_NONE, 16'd7, "ill_p4");
    repeat (2) tick(S_HALT, 3'd0, F_ILL, 16'd7, "ill_halt");
    go = 1'b1;
    tick(S_HALT, 3'd0, F_ILL, 16'd7, "ill_go");
    go = 1'b0;

    // Reset asserted mid-stall in phase 1, sampled before the next clock edge
    opcode = OP_LDA;
    tick(S_P0, 3'd0, F_NONE, 16'd7, "rs_p0");
    mem_rdy = 1'b0;
    repeat (2) tick(S_P1, 3'd1, F_NONE, 16'd7, "rs_p1_stall");
    rst_ = 1'b0;
    tick(S_P0, 3'd0, F_NONE, 16'd0, "rst_mid_stall");
    mem_rdy = 1'b1;
    rst_    = 1'b1;
    tick(S_P0, 3'd0, F_NONE, 16'd0, "rst_release");
    tick(S_P1, 3'd1, F_NONE, 16'd0, "post_rst_p1");

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_control_ws.md
Name: risc_control_ws

Overview:
Parametrised next-generation instruction sequencer for the 8-opcode accumulator RISC CPU. It drives the same datapath strobes through the 8-phase fetch/execute cycle as the current control unit, and adds:
- memory wait-state handshake with timeout
- a latched halt state released by a go input
- single-step mode
- illegal-opcode detection for wider opcode fields
- a retired-instruction counter

It sits between the instruction register/ALU zero flag and the memory, PC and accumulator load controls.

Parameters:
OP_W, 3, opcode width (>=3); bits [2:0] select the operation, any nonzero bit above [2] is illegal
RDY_TIMEOUT, 16, consecutive stall cycles before bus error; 0 disables the timeout
TO_W, 5, stall counter width; must hold RDY_TIMEOUT
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock, rising edge
rst_  in  1  asynchronous active-low reset
zero  in  1  accumulator-zero flag
opcode  in  OP_W  IR opcode field; stable from phase 3 through phase 7
mem_rdy  in  1  memory ready; sampled only in stall phases
go  in  1  resume from HALTED/PAUSE; single-cycle pulse
step_en  in  1  single-step mode enable
rd  out  1  memory read
wr  out  1  memory write
ld_ir  out  1  load instruction register
ld_ac  out  1  load accumulator
ld_pc  out  1  load PC
inc_pc  out  1  increment PC
halt  out  1  CPU halted
data_e  out  1  accumulator drives the data bus
sel  out  1  address mux selects PC (1) or IR operand (0)
phase  out  3  current phase; 0 when not RUN
paused  out  1  in PAUSE state
ill_op  out  1  sticky illegal-opcode flag
bus_err  out  1  sticky memory-timeout flag
instr_cnt  out  CNT_W  retired instruction count

Behaviour:
Opcodes [2:0]: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7. ALUOP = ADD, AND, XOR or LDA.

Top-level states are RUN (holds phase 0..7), HALTED and PAUSE. Strobes are a combinational decode of the registered state, opcode and zero. Strobes per RUN phase:
- Phase 0: sel
- Phase 1: sel, rd
- Phase 2: sel, rd, ld_ir
- Phase 3: sel, rd
- Phase 4: inc_pc; halt if HLT
- Phase 5: rd if ALUOP
- Phase 6: rd if ALUOP; inc_pc if SKZ&zero; ld_pc if JMP; data_e if STO
- Phase 7: rd and ld_ac if ALUOP; ld_pc if JMP; wr and data_e if STO

Phase advance and stalls:
- Phase advances by 1 each cycle except in stall phases.
- Stall phases: phase 1 (always), phase 5 (ALUOP only), phase 7 (STO only). The phase advances only on a cycle with mem_rdy=1.
- While stalled, all strobes are held steady, so ld_ir, ld_ac, ld_pc and inc_pc still pulse exactly as decoded.
- mem_rdy is ignored in non-stall phases.

Stall timeout:
- The stall counter resets to 0 on entering any phase and increments on each stalled cycle.
- If RDY_TIMEOUT>0 and the counter reaches RDY_TIMEOUT with mem_rdy still 0, the next edge enters HALTED with bus_err=1.

Phase 4 exits:
- HLT: the next edge enters HALTED.
- Illegal opcode (OP_W>3 and opcode[OP_W-1:3]!=0): the next edge enters HALTED with ill_op=1.
- Illegal opcodes otherwise decode as HLT, so no other strobes are asserted.

Phase 7 exit (retire):
- instr_cnt increments, wrapping modulo 2^CNT_W.
- Next state is PAUSE if step_en=1, else phase 0.
- HLT and illegal opcodes never retire.

HALTED:
- halt=1; all other strobes 0; phase=0.
- go=1 -> phase 0 on the next edge, clearing ill_op and bus_err on the same edge.

PAUSE:
- paused=1; all strobes 0.
- go=1 -> phase 0.

go in RUN is ignored. step_en changes take effect only at the next phase-7 exit.

Reset (asynchronous, immediate, including mid-stall):
- State RUN, phase 0, so sel=1 and all other strobes 0.
- Stall counter 0, instr_cnt 0, ill_op=0, bus_err=0, paused=0.

Test Plan:
- Reset release, mem_rdy=1, opcode=LDA, zero=0 -> phases 0..7 repeat every 8 cycles; rd high in phases 1,2,3,5,6,7; ld_ir only in phase 2; ld_ac only in phase 7; instr_cnt=1 after the first 8 cycles.
- mem_rdy=0 for 3 cycles on entering phase 1, opcode=STO, then mem_rdy=0 for 2 cycles in phase 7 -> phase 1 lasts 4 cycles with sel/rd steady; ld_ir is high for 1 cycle; wr and data_e are held 3 cycles in phase 7; the instruction takes 13 cycles; instr_cnt +1.
- SKZ with zero=1 -> inc_pc high in phase 4 and phase 6; with zero=0 -> inc_pc high in phase 4 only; ld_pc never asserted. JMP -> ld_pc high in phases 6 and 7.
- HLT -> halt=1 from phase 4 onward, held across 10 idle cycles with all other strobes 0; a go pulse gives phase 0 and sel=1 on the next cycle; instr_cnt unchanged.
- RDY_TIMEOUT=4, opcode=ADD, mem_rdy stuck 0 in phase 5 -> after 4 stalled cycles bus_err=1 and halt=1; a go pulse clears bus_err; step_en=1 -> paused=1 after phase 7 until go.
- OP_W=4, opcode=4'b1010 -> ill_op=1 and halt=1 after phase 4, no ld_ac. rst_ asserted mid-stall in phase 1 -> phase=0 and sel=1 immediately, before the next clk edge.
